// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: machine-cycle names, fetch phases,
// opcode constants and instruction-class helpers also used by the decoder.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} cycle_e;

  typedef enum logic {FIRST, SECOND} phase_e;

  localparam logic [3:0] OPR_JCN = 4'h1;
  localparam logic [3:0] OPR_FIM = 4'h2;
  localparam logic [3:0] OPR_FIN = 4'h3;  // FIN and JIN share opr 3, split by opa[0]
  localparam logic [3:0] OPR_JUN = 4'h4;
  localparam logic [3:0] OPR_JMS = 4'h5;
  localparam logic [3:0] OPR_ISZ = 4'h7;
  localparam logic [3:0] OPR_BBL = 4'hC;

  function automatic logic is_fin(input logic [3:0] opr, input logic [3:0] opa);
    return (opr == OPR_FIN) && !opa[0];
  endfunction

  function automatic logic is_jin(input logic [3:0] opr, input logic [3:0] opa);
    return (opr == OPR_FIN) && opa[0];
  endfunction

  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
    return (opr inside {OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ}) ||
           ((opr == OPR_FIM) && !opa[0]);
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_stack.sv
// Circular return-address stack: push writes at sp and advances it, pop steps back.
// No overflow/underflow tracking; a fourth push silently replaces the oldest entry.
module pc_stack #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        push,
  input  logic        pop,
  input  logic [11:0] push_data,
  output logic [11:0] pop_data,
  output logic [1:0]  sp
);

  localparam logic [1:0] LAST = 2'(DEPTH - 1);

  logic [11:0] entries [DEPTH];
  logic [1:0]  sp_up;
  logic [1:0]  sp_down;

  assign sp_up    = (sp == LAST) ? 2'd0 : sp + 2'd1;
  assign sp_down  = (sp == 2'd0) ? LAST : sp - 2'd1;
  assign pop_data = entries[sp_down];

  // NOTE: the entries are reset because the block must come out of reset with a
  // defined stack; a large RAM would normally be left unreset and only sp cleared.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (push) begin
      entries[sp] <= push_data;
      sp          <= sp_up;
    end else if (pop) begin
      sp <= sp_down;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: 8-state machine cycle, ROM fetch, two-word handling,
// FIN indirect fetch, JIN/BBL, program counter and return-address stack.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int STACK_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        clkEn,
  input  logic [7:0]  romData,
  input  logic        ccIn,
  input  logic        iszZeroIn,
  input  logic [7:0]  pairData,
  output logic [2:0]  cycle,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  output logic        secondWord,
  output logic [7:0]  secondData,
  output logic [11:0] romAddr,
  output logic        romRe,
  output logic [11:0] pc,
  output logic [1:0]  sp
);

  cycle_e      cyc_q, cyc_d;
  phase_e      phase_q, phase_d;
  logic [3:0]  opr_d, opa_d;
  logic [7:0]  second_data_d;
  logic [11:0] rom_addr_d, pc_d;
  logic        rom_re_d;
  logic        push, pop;
  logic [11:0] pop_data;
  logic [11:0] pc_inc;

  assign cycle      = cyc_q;
  assign secondWord = (phase_q == SECOND);
  assign pc_inc     = pc + 12'd1;

  pc_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .rstN      (rstN),
    .push      (push && clkEn),
    .pop       (pop && clkEn),
    .push_data (pc),
    .pop_data  (pop_data),
    .sp        (sp)
  );

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    cyc_d         = cycle_e'(cyc_q + 3'd1);
    phase_d       = phase_q;
    opr_d         = opr;
    opa_d         = opa;
    second_data_d = secondData;
    rom_addr_d    = romAddr;
    pc_d          = pc;
    push          = 1'b0;
    pop           = 1'b0;

    case (cyc_q)
      M1: begin
        if (phase_q == FIRST) begin
          opr_d = romData[7:4];
          opa_d = romData[3:0];
          pc_d  = pc_inc;
        end else begin
          second_data_d = romData;
          if (!is_fin(opr, opa)) pc_d = pc_inc;
        end
      end
      X3: begin
        if (phase_q == FIRST) begin
          if (is_two_word(opr, opa) || is_fin(opr, opa)) begin
            phase_d    = SECOND;
            rom_addr_d = is_fin(opr, opa) ? {pc[11:8], pairData} : pc;
          end else if (is_jin(opr, opa)) begin
            pc_d       = {pc[11:8], pairData};
            rom_addr_d = pc_d;
          end else if (opr == OPR_BBL) begin
            pop        = 1'b1;
            pc_d       = pop_data;
            rom_addr_d = pop_data;
          end else begin
            rom_addr_d = pc;
          end
        end else begin
          // Short jumps use the post-increment page, so a second word at xFF lands in the next page.
          phase_d = FIRST;
          case (opr)
            OPR_JUN: pc_d = {opa, secondData};
            OPR_JMS: begin
              push = 1'b1;
              pc_d = {opa, secondData};
            end
            OPR_JCN: if (ccIn)       pc_d = {pc[11:8], secondData};
            OPR_ISZ: if (!iszZeroIn) pc_d = {pc[11:8], secondData};
            default: ;
          endcase
          rom_addr_d = pc_d;
        end
      end
      default: ;
    endcase

    rom_re_d = (cyc_d == M1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cyc_q      <= A1;
      phase_q    <= FIRST;
      opr        <= '0;
      opa        <= '0;
      secondData <= '0;
      romAddr    <= '0;
      romRe      <= 1'b0;
      pc         <= '0;
    end else if (clkEn) begin
      cyc_q      <= cyc_d;
      phase_q    <= phase_d;
      opr        <= opr_d;
      opa        <= opa_d;
      secondData <= second_data_d;
      romAddr    <= rom_addr_d;
      romRe      <= rom_re_d;
      pc         <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: ROM array, instruction-level reference
// model compared every cycle, plus directed programs with literal expectations.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        clkEn = 1'b1;
  logic [7:0]  romData;
  logic        ccIn = 1'b0;
  logic        iszZeroIn = 1'b0;
  logic [7:0]  pairData = 8'h00;
  logic [2:0]  cycle;
  logic [3:0]  opr, opa;
  logic        secondWord;
  logic [7:0]  secondData;
  logic [11:0] romAddr;
  logic        romRe;
  logic [11:0] pc;
  logic [1:0]  sp;

  logic [7:0]  rom [4096];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          run_cmp = 1'b0;

  assign romData = rom[romAddr];

  fetch_sequencer dut (
    .clk        (clk),
    .rstN       (rstN),
    .clkEn      (clkEn),
    .romData    (romData),
    .ccIn       (ccIn),
    .iszZeroIn  (iszZeroIn),
    .pairData   (pairData),
    .cycle      (cycle),
    .opr        (opr),
    .opa        (opa),
    .secondWord (secondWord),
    .secondData (secondData),
    .romAddr    (romAddr),
    .romRe      (romRe),
    .pc         (pc),
    .sp         (sp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic over addresses modulo 4096 and a 3-slot ring.
  int m_cyc = 0, m_pc = 0, m_addr = 0, m_opr = 0, m_opa = 0, m_sdata = 0, m_sp = 0;
  int m_stk [3] = '{0, 0, 0};
  bit m_second = 0, m_re = 0;
  bit m_is_fin, m_is_jin, m_is_two;
  int m_byte;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_cyc = 0; m_pc = 0; m_addr = 0; m_opr = 0; m_opa = 0; m_sdata = 0; m_sp = 0;
      m_second = 0; m_re = 0;
      for (int i = 0; i < 3; i++) m_stk[i] = 0;
    end else if (clkEn) begin
      m_is_fin = (m_opr == 3) && (m_opa % 2 == 0);
      m_is_jin = (m_opr == 3) && (m_opa % 2 == 1);
      m_is_two = (m_opr == 1) || (m_opr == 4) || (m_opr == 5) || (m_opr == 7) ||
                 ((m_opr == 2) && (m_opa % 2 == 0));
      if (m_cyc == 3) begin
        m_byte = int'(rom[m_addr]);
        if (!m_second) begin
          m_opr = m_byte / 16;
          m_opa = m_byte % 16;
          m_pc  = (m_pc + 1) % 4096;
        end else begin
          m_sdata = m_byte;
          if (!m_is_fin) m_pc = (m_pc + 1) % 4096;
        end
      end else if (m_cyc == 7) begin
        if (!m_second) begin
          if (m_is_two || m_is_fin) begin
            m_second = 1;
            m_addr = m_is_fin ? (m_pc / 256) * 256 + int'(pairData) : m_pc;
          end else if (m_is_jin) begin
            m_pc = (m_pc / 256) * 256 + int'(pairData);
            m_addr = m_pc;
          end else if (m_opr == 12) begin
            m_sp = (m_sp + 2) % 3;
            m_pc = m_stk[m_sp];
            m_addr = m_pc;
          end else begin
            m_addr = m_pc;
          end
        end else begin
          m_second = 0;
          if (m_opr == 4) m_pc = m_opa * 256 + m_sdata;
          else if (m_opr == 5) begin
            m_stk[m_sp] = m_pc;
            m_sp = (m_sp + 1) % 3;
            m_pc = m_opa * 256 + m_sdata;
          end
          else if ((m_opr == 1 && ccIn) || (m_opr == 7 && !iszZeroIn))
            m_pc = (m_pc / 256) * 256 + m_sdata;
          m_addr = m_pc;
        end
      end
      m_cyc = (m_cyc + 1) % 8;
      m_re  = (m_cyc == 3);
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_cycle", int'(cycle), m_cyc);
      check("cmp_opr", int'(opr), m_opr);
      check("cmp_opa", int'(opa), m_opa);
      check("cmp_secondWord", int'(secondWord), int'(m_second));
      check("cmp_secondData", int'(secondData), m_sdata);
      check("cmp_romAddr", int'(romAddr), m_addr);
      check("cmp_romRe", int'(romRe), int'(m_re));
      check("cmp_pc", int'(pc), m_pc);
      check("cmp_sp", int'(sp), m_sp);
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rstN = 1'b0;
    #10 rstN = 1'b1;
  endtask

  task automatic run_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    // All-zero ROM: NOP stream
    clear_rom();
    do_reset();
    run_cmp = 1'b1;
    check("rst_cycle", int'(cycle), 0);
    check("rst_romAddr", int'(romAddr), 12'h000);
    check("rst_pc", int'(pc), 0);
    check("rst_romRe", int'(romRe), 0);
    check("rst_sp", int'(sp), 0);
    run_clk(3);
    check("nop_romRe_m1", int'(romRe), 1);
    run_clk(5);
    check("nop_romAddr_1", int'(romAddr), 12'h001);
    check("nop_romRe_a1", int'(romRe), 0);
    run_clk(16);
    check("nop_romAddr_3", int'(romAddr), 12'h003);

    // JUN 123
    clear_rom();
    rom[12'h000] = 8'h41; rom[12'h001] = 8'h23;
    do_reset();
    run_clk(8);
    check("jun_secondWord", int'(secondWord), 1);
    check("jun_second_addr", int'(romAddr), 12'h001);
    run_clk(8);
    check("jun_secondData", int'(secondData), 8'h23);
    check("jun_romAddr", int'(romAddr), 12'h123);
    check("jun_secondWord_clr", int'(secondWord), 0);

    // JMS 200 / BBL
    clear_rom();
    rom[12'h000] = 8'h52; rom[12'h001] = 8'h00; rom[12'h200] = 8'hC5;
    do_reset();
    run_clk(16);
    check("jms_romAddr", int'(romAddr), 12'h200);
    check("jms_sp", int'(sp), 1);
    run_clk(8);
    check("bbl_romAddr", int'(romAddr), 12'h002);
    check("bbl_sp", int'(sp), 0);

    // JCN across a page boundary, taken then not taken
    clear_rom();
    rom[12'h000] = 8'h40; rom[12'h001] = 8'hFE;
    rom[12'h0FE] = 8'h14; rom[12'h0FF] = 8'h40;
    ccIn = 1'b1;
    do_reset();
    run_clk(16);
    check("jcn_pre_addr", int'(romAddr), 12'h0FE);
    run_clk(16);
    check("jcn_taken", int'(romAddr), 12'h140);
    ccIn = 1'b0;
    do_reset();
    run_clk(32);
    check("jcn_not_taken", int'(romAddr), 12'h100);

    // FIN from 305 via pair 37
    clear_rom();
    rom[12'h000] = 8'h43; rom[12'h001] = 8'h05;
    rom[12'h305] = 8'h30; rom[12'h337] = 8'hAB;
    pairData = 8'h37;
    do_reset();
    run_clk(16);
    check("fin_pre_addr", int'(romAddr), 12'h305);
    run_clk(8);
    check("fin_indirect_addr", int'(romAddr), 12'h337);
    check("fin_pc_first", int'(pc), 12'h306);
    run_clk(8);
    check("fin_data", int'(secondData), 8'hAB);
    check("fin_pc_held", int'(pc), 12'h306);
    check("fin_next_addr", int'(romAddr), 12'h306);

    // JIN then ISZ, taken then not taken
    clear_rom();
    rom[12'h000] = 8'h31; rom[12'h010] = 8'h70; rom[12'h011] = 8'h40;
    pairData = 8'h10;
    iszZeroIn = 1'b0;
    do_reset();
    run_clk(8);
    check("jin_romAddr", int'(romAddr), 12'h010);
    check("jin_pc", int'(pc), 12'h010);
    run_clk(16);
    check("isz_taken", int'(romAddr), 12'h040);
    iszZeroIn = 1'b1;
    do_reset();
    run_clk(24);
    check("isz_not_taken", int'(romAddr), 12'h012);
    iszZeroIn = 1'b0;

    // Four nested JMS, four BBL: oldest return address overwritten
    clear_rom();
    rom[12'h000] = 8'h51; rom[12'h100] = 8'h52; rom[12'h200] = 8'h53; rom[12'h300] = 8'h54;
    rom[12'h400] = 8'hC0; rom[12'h302] = 8'hC0; rom[12'h202] = 8'hC0; rom[12'h102] = 8'hC0;
    do_reset();
    run_clk(64);
    check("nest_call4", int'(romAddr), 12'h400);
    check("nest_sp_wrap", int'(sp), 1);
    run_clk(8);
    check("nest_ret1", int'(romAddr), 12'h302);
    run_clk(8);
    check("nest_ret2", int'(romAddr), 12'h202);
    run_clk(8);
    check("nest_ret3", int'(romAddr), 12'h102);
    run_clk(8);
    check("nest_ret4", int'(romAddr), 12'h302);

    // clkEn low for 5 clocks during M2
    clear_rom();
    rom[12'h000] = 8'h41; rom[12'h001] = 8'h23;
    do_reset();
    run_clk(4);
    clkEn = 1'b0;
    run_clk(5);
    check("frz_cycle", int'(cycle), 4);
    check("frz_opr", int'(opr), 4);
    check("frz_opa", int'(opa), 1);
    check("frz_pc", int'(pc), 1);
    check("frz_romAddr", int'(romAddr), 0);
    clkEn = 1'b1;
    run_clk(4);
    check("frz_resume_addr", int'(romAddr), 12'h001);
    check("frz_resume_sw", int'(secondWord), 1);

    // Async reset pulse at X2 after a JMS
    clear_rom();
    rom[12'h000] = 8'h52; rom[12'h001] = 8'h00;
    do_reset();
    run_clk(22);
    check("arst_pre_cycle", int'(cycle), 6);
    check("arst_pre_sp", int'(sp), 1);
    rstN = 1'b0;
    #1;
    check("arst_cycle", int'(cycle), 0);
    check("arst_sp", int'(sp), 0);
    check("arst_pc", int'(pc), 0);
    check("arst_romAddr", int'(romAddr), 0);
    check("arst_opr", int'(opr), 0);
    check("arst_secondData", int'(secondData), 0);
    #9 rstN = 1'b1;
    run_clk(8);
    check("arst_refetch", int'(romAddr), 12'h001);
    check("arst_refetch_sw", int'(secondWord), 1);

    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
